// File: rtl/lif_pkg.sv
// Shared types, defaults and arithmetic helpers for the LIF reservoir ring.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } lif_state_t;

    localparam int DEF_N_NEURONS  = 10;
    localparam int DEF_IN_W       = 32;
    localparam int DEF_V_W        = 16;
    localparam int DEF_V_TH       = 1024;
    localparam int DEF_W_IN       = 32;
    localparam int DEF_W_REC      = 256;
    localparam int DEF_LEAK_SHIFT = 3;
    localparam int DEF_REFRAC     = 2;
    localparam int DEF_STRIDE     = 1;
    localparam int DEF_MODE       = 0;
    localparam int DEF_WINDOW     = 16;

    // Inputs wider than 64 bits are not supported by this helper.
    function automatic int popcount(input logic [63:0] x);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) c++;
        end
        return c;
    endfunction

    function automatic longint saturate(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire cell: membrane, refractory timer,
// spike register and per-sample spike counter.
module lif_cell
    import lif_pkg::*;
#(
    parameter int V_W        = DEF_V_W,
    parameter int DW         = DEF_V_W + 7,
    parameter int V_TH       = DEF_V_TH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC,
    parameter int CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_cnt,
    input  logic signed [DW-1:0] drive,
    output logic                 spike,
    output logic [CNT_W-1:0]     count
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [V_W-1:0] V_TH_S = V_W'(V_TH);

    logic signed [V_W-1:0] v;
    logic [RW-1:0]         refr;
    logic signed [DW-1:0]  vn_wide;
    logic signed [V_W-1:0] vn_sat;
    logic                  fire;

    // Leak and drive are summed wide so only the final value saturates.
    always_comb begin
        vn_wide = DW'(v) - DW'(v >>> LEAK_SHIFT) + drive;
        vn_sat  = V_W'(saturate(longint'(vn_wide), V_W));
        fire    = (refr == '0) && (vn_sat >= V_TH_S);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v     <= '0;
            refr  <= '0;
            spike <= 1'b0;
            count <= '0;
        end else begin
            if (clr_cnt) begin
                count <= '0;
            end else if (en && fire) begin
                count <= count + 1'b1;
            end

            if (!en) begin
                spike <= 1'b0;
            end else if (refr != '0) begin
                v     <= '0;
                refr  <= refr - 1'b1;
                spike <= 1'b0;
            end else if (fire) begin
                v     <= '0;
                refr  <= RW'(REFRAC);
                spike <= 1'b1;
            end else begin
                v     <= vn_sat;
                spike <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lif_reservoir_ring.sv
// Ring reservoir of LIF cells: one input sample integrated for WINDOW
// ticks, per-cell spike counts handed on with a valid/ready handshake.
module lif_reservoir_ring
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int IN_W       = DEF_IN_W,
    parameter int V_W        = DEF_V_W,
    parameter int V_TH       = DEF_V_TH,
    parameter int W_IN       = DEF_W_IN,
    parameter int W_REC      = DEF_W_REC,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int MODE       = DEF_MODE,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int CNT_W      = $clog2(WINDOW + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_bits,
    output logic [N_NEURONS-1:0]       spikes_o,
    output logic                       busy,
    output logic                       state_valid,
    input  logic                       state_ready,
    output logic [N_NEURONS*CNT_W-1:0] state_counts
);

    localparam int DW = V_W + $clog2(IN_W) + 2;
    localparam int TW = $clog2(WINDOW + 1);
    localparam logic signed [DW-1:0] REC_W = DW'(W_REC);

    lif_state_t state;
    lif_state_t state_nx;

    logic [TW-1:0]        tick;
    logic [IN_W-1:0]      in_lat;
    logic                 accept;
    logic                 run_en;
    logic signed [DW-1:0] base_drive;
    logic [N_NEURONS-1:0] spk;

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        state_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (tick == TW'(WINDOW - 1)) state_nx = DONE;
            end
            DONE: begin
                state_valid = 1'b1;
                if (state_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign run_en = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            tick   <= '0;
            in_lat <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                in_lat <= in_bits;
                tick   <= '0;
            end else if (run_en) begin
                tick <= tick + 1'b1;
            end
        end
    end

    assign base_drive = DW'(popcount(64'(in_lat)) * W_IN);
    assign spikes_o   = spk;

    // spk is the previous tick's spike vector, giving one tick of
    // recurrent delay; it is zero on the first tick after IDLE.
    for (genvar i = 0; i < N_NEURONS; i++) begin : g_cell
        localparam int SRC  = (i + N_NEURONS - (STRIDE % N_NEURONS)) % N_NEURONS;
        localparam int SRC2 = (i + STRIDE) % N_NEURONS;

        logic signed [DW-1:0] drive;

        always_comb begin
            drive = base_drive;
            if (spk[SRC]) drive = drive + REC_W;
            if (MODE == 1 && spk[SRC2]) drive = drive + REC_W;
        end

        lif_cell #(
            .V_W       (V_W),
            .DW        (DW),
            .V_TH      (V_TH),
            .LEAK_SHIFT(LEAK_SHIFT),
            .REFRAC    (REFRAC),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (run_en),
            .clr_cnt(accept),
            .drive  (drive),
            .spike  (spk[i]),
            .count  (state_counts[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_lif_reservoir_ring.sv
// Directed self-checking bench for lif_reservoir_ring at default parameters.
module tb_lif_reservoir_ring;

    localparam int N  = 10;
    localparam int CW = 5;
    localparam int WIN = 16;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_bits;
    logic [N-1:0]    spikes_o;
    logic            busy;
    logic            state_valid;
    logic            state_ready;
    logic [N*CW-1:0] state_counts;

    int pass_cnt = 0;
    int total_cnt = 0;
    int lat;
    logic [N-1:0] spk_hist [0:WIN];

    lif_reservoir_ring dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bits     (in_bits),
        .spikes_o    (spikes_o),
        .busy        (busy),
        .state_valid (state_valid),
        .state_ready (state_ready),
        .state_counts(state_counts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cnt_of(input int i);
        return state_counts[i*CW +: CW];
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Offer one sample, then record spikes_o per tick until state_valid.
    task automatic run_sample(input logic [31:0] bits);
        in_bits  = bits;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat <= WIN) spk_hist[lat] = spikes_o;
            if (state_valid) break;
        end
        total_cnt++;
        if (lat !== WIN || state_valid !== 1'b1)
            $display("FAIL latency: got %0d valid=%b, expected %0d", lat, state_valid, WIN);
        else pass_cnt++;
    endtask

    task automatic ack();
        state_ready = 1'b1;
        @(posedge clk);
        #1;
        state_ready = 1'b0;
    endtask

    task automatic check_counts(input string nm, input int exp);
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (cnt_of(i) !== CW'(exp))
                $display("FAIL %s cell%0d: got %0d, expected %0d", nm, i, cnt_of(i), exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({in_ready, state_valid, busy} !== 3'b100 || spikes_o !== '0)
            $display("FAIL reset_outputs: rdy/val/busy=%b spk=%h, expected 100 spk=0",
                     {in_ready, state_valid, busy}, spikes_o);
        else pass_cnt++;
        check_counts("reset_counts", 0);
    endtask

    task automatic test_zero_input();
        do_reset();
        run_sample(32'h0);
        check_counts("zero_counts", 0);
        ack();
    endtask

    task automatic test_full_drive();
        logic [N-1:0] exp;
        do_reset();
        run_sample(32'hFFFF_FFFF);
        for (int t = 1; t <= WIN; t++) begin
            exp = ((t - 1) % 3 == 0) ? '1 : '0;
            total_cnt++;
            if (spk_hist[t] !== exp)
                $display("FAIL full_spk_t%0d: got %h, expected %h", t, spk_hist[t], exp);
            else pass_cnt++;
        end
        check_counts("full_counts", 6);
        ack();
    endtask

    task automatic test_carry_over();
        logic seen;
        do_reset();
        run_sample(32'h1);
        seen = 1'b0;
        for (int t = 1; t <= WIN; t++) if (spk_hist[t] !== '0) seen = 1'b1;
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL weak_no_spike: got spike, expected none");
        else pass_cnt++;
        check_counts("weak_counts", 0);
        ack();
        run_sample(32'hFFFF_FFFF);
        total_cnt++;
        if (spk_hist[1] !== '1 || spk_hist[2] !== '0)
            $display("FAIL carry_first_tick: got %h/%h, expected 3ff/000", spk_hist[1], spk_hist[2]);
        else pass_cnt++;
        check_counts("carry_counts", 6);
        ack();
    endtask

    task automatic test_backpressure();
        logic [N*CW-1:0] snap;
        do_reset();
        run_sample(32'hFFFF_FFFF);
        snap = state_counts;
        in_bits  = 32'h0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (state_counts !== snap || in_ready !== 1'b0 || state_valid !== 1'b1 || busy !== 1'b0)
                $display("FAIL hold_c%0d: cnt=%h rdy=%b val=%b, expected cnt=%h rdy=0 val=1",
                         c, state_counts, in_ready, state_valid, snap);
            else pass_cnt++;
        end
        state_ready = 1'b1;
        @(posedge clk);
        #1;
        state_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || state_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL release_idle: rdy=%b val=%b busy=%b, expected 1 0 0",
                     in_ready, state_valid, busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL accept_after_release: busy=%b rdy=%b, expected 1 0", busy, in_ready);
        else pass_cnt++;
        for (int k = 0; k < 40 && !state_valid; k++) @(posedge clk);
        #1;
        check_counts("post_release_counts", 0);
        ack();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        in_bits  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || state_valid !== 1'b0 || spikes_o !== '0)
            $display("FAIL midrun_reset: rdy=%b busy=%b val=%b spk=%h, expected 1 0 0 0",
                     in_ready, busy, state_valid, spikes_o);
        else pass_cnt++;
        check_counts("midrun_counts", 0);
        run_sample(32'hFFFF_FFFF);
        check_counts("rerun_counts", 6);
        ack();
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_bits     = '0;
        state_ready = 1'b0;
        test_reset();
        test_zero_input();
        test_full_drive();
        test_carry_over();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
